// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding-mode enum, exception-flag struct, operand class
// struct and the exponent-bias helper used by the multiplier pipeline.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    // Bit order matches the RISC-V fflags CSR: {NV,DZ,OF,UF,NX}.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    typedef struct packed {
        logic sign;
        logic inf;
        logic nan;
        logic zero;
    } fp_class_t;

    function automatic int unsigned bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fround.sv
// Combinational round / range-check / pack for the last multiplier stage.
//   cls_i    : result class (sign, inf, nan, zero) decided in stage 0
//   nv_i     : invalid-operation flag from stage 0 (inf * zero)
//   rm_i     : rounding mode
//   exp_i    : signed unbiased-plus-bias exponent, EW+2 bits, before rounding
//   prod_i   : normalised product without the hidden bit, 2*FW+1 bits
//   result_o : packed IEEE result {sign, exp, frac}
//   flags_o  : exception flags
module fround
    import fpu_pkg::*;
#(
    parameter int unsigned FW = 23,
    parameter int unsigned EW = 8
) (
    input  fp_class_t               cls_i,
    input  logic                    nv_i,
    input  rm_e                     rm_i,
    input  logic signed [EW+1:0]    exp_i,
    input  logic        [2*FW:0]    prod_i,
    output logic        [EW+FW:0]   result_o,
    output fflags_t                 flags_o
);

    localparam logic signed [EW+1:0] ExpZero = '0;
    localparam logic signed [EW+1:0] ExpInf  = $signed({2'b00, {EW{1'b1}}});

    logic [FW-1:0]        frac;
    logic [FW-1:0]        frac_r;
    logic                 guard;
    logic                 sticky;
    logic                 inexact;
    logic                 round_up;
    logic                 carry;
    logic                 to_inf;
    logic signed [EW+1:0] exp_r;

    always_comb begin
        frac    = prod_i[2*FW:FW+1];
        guard   = prod_i[FW];
        sticky  = |prod_i[FW-1:0];
        inexact = guard | sticky;

        round_up = 1'b0;
        to_inf   = 1'b0;
        case (rm_i)
            RNE: begin
                round_up = guard & (sticky | frac[0]);
                to_inf   = 1'b1;
            end
            RTZ: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
            RDN: begin
                round_up = cls_i.sign & inexact;
                to_inf   = cls_i.sign;
            end
            RUP: begin
                round_up = ~cls_i.sign & inexact;
                to_inf   = ~cls_i.sign;
            end
            RMM: begin
                round_up = guard;
                to_inf   = 1'b1;
            end
            default: begin
                round_up = 1'b0;
                to_inf   = 1'b0;
            end
        endcase

        // Carry out of the fraction means the significand became 10.0..0: frac wraps to 0
        // and the exponent steps up by one.
        {carry, frac_r} = {1'b0, frac} + {{FW{1'b0}}, round_up};
        exp_r = exp_i + $signed({{(EW+1){1'b0}}, carry});

        result_o = '0;
        flags_o  = '0;
        if (cls_i.nan) begin
            result_o   = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
            flags_o.nv = nv_i;
        end else if (cls_i.inf) begin
            result_o = {cls_i.sign, {EW{1'b1}}, {FW{1'b0}}};
        end else if (cls_i.zero) begin
            result_o = {cls_i.sign, {(EW+FW){1'b0}}};
        end else if (exp_i <= ExpZero) begin
            // No subnormal support: anything below the normal range flushes to zero.
            result_o   = {cls_i.sign, {(EW+FW){1'b0}}};
            flags_o.uf = 1'b1;
            flags_o.nx = 1'b1;
        end else if (exp_r >= ExpInf) begin
            if (to_inf) begin
                result_o = {cls_i.sign, {EW{1'b1}}, {FW{1'b0}}};
            end else begin
                result_o = {cls_i.sign, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
            end
            flags_o.of = 1'b1;
            flags_o.nx = 1'b1;
        end else begin
            result_o   = {cls_i.sign, exp_r[EW-1:0], frac_r};
            flags_o.nx = inexact;
        end
    end

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 multiplier with valid/ready handshake and tag sideband.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operation handshake (in_ready is combinational from out_ready)
//   in_tag, rm            : sideband tag and rounding mode for the operation
//   expA/B, sigA/B        : biased exponents and significands with hidden bit
//   signA/B..zeroA/B      : operand class bits
//   out_valid/out_ready   : result handshake; outputs hold while stalled
//   out_tag, result       : tag and packed IEEE result
//   fflags                : {NV,DZ,OF,UF,NX}
// Stage 0 multiplies and normalises, middle stages only register, and the last stage
// captures the output of fround.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned FW   = 23,
    parameter int unsigned EW   = 8,
    parameter int unsigned LAT  = 3,
    parameter int unsigned TAGW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAGW-1:0]   in_tag,
    input  logic [2:0]        rm,
    input  logic [EW-1:0]     expA,
    input  logic [EW-1:0]     expB,
    input  logic [FW:0]       sigA,
    input  logic [FW:0]       sigB,
    input  logic              signA,
    input  logic              signB,
    input  logic              infA,
    input  logic              infB,
    input  logic              nanA,
    input  logic              nanB,
    input  logic              zeroA,
    input  logic              zeroB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAGW-1:0]   out_tag,
    output logic [EW+FW:0]    result,
    output logic [4:0]        fflags
);

    localparam logic [EW+1:0] BiasW  = (EW+2)'(bias(EW));
    localparam logic [EW+1:0] ExpOne = (EW+2)'(1);

    typedef struct packed {
        logic [TAGW-1:0] tag;
        rm_e             rm;
        fp_class_t       cls;
        logic            nv;
        logic [EW+1:0]   exp;   // signed
        logic [2*FW:0]   prod;  // normalised, hidden bit dropped
    } stage_t;

    logic [LAT-1:0]   v_q;
    logic [LAT-1:0]   v_d;
    logic [LAT-1:0]   ready;
    logic             chain;
    stage_t           s0_d;
    stage_t           pipe_q [LAT-1];
    stage_t           tail;

    logic [EW+1:0]    e_sum;
    logic [2*FW+1:0]  prod_raw;
    logic             inf_x_zero;
    logic             nan_any;

    logic [EW+FW:0]   rnd_result;
    fflags_t          rnd_flags;
    logic             out_load;
    logic [EW+FW:0]   result_q;
    logic [EW+FW:0]   result_d;
    logic [TAGW-1:0]  tag_q;
    logic [TAGW-1:0]  tag_d;
    fflags_t          flags_q;
    fflags_t          flags_d;

    // ready[k]: stage k may load this cycle. It is true if stage k or any stage after it
    // is empty, or the consumer is taking the result, so bubbles collapse.
    always_comb begin
        chain = out_ready;
        ready = '0;
        for (int k = int'(LAT) - 1; k >= 0; k--) begin
            chain    = chain | ~v_q[k];
            ready[k] = chain;
        end
    end

    assign in_ready = ready[0];

    always_comb begin
        v_d    = v_q;
        v_d[0] = ready[0] ? in_valid : v_q[0];
        for (int k = 1; k < int'(LAT); k++) begin
            v_d[k] = ready[k] ? v_q[k-1] : v_q[k];
        end
    end

    // Stage 0: exponent sum, product and normalisation by at most one place.
    always_comb begin
        e_sum      = {2'b00, expA} + {2'b00, expB} - BiasW;
        prod_raw   = {{(FW+1){1'b0}}, sigA} * {{(FW+1){1'b0}}, sigB};
        inf_x_zero = (infA & zeroB) | (zeroA & infB);
        nan_any    = nanA | nanB | inf_x_zero;

        s0_d          = '0;
        s0_d.tag      = in_tag;
        s0_d.rm       = rm_e'(rm);
        s0_d.nv       = inf_x_zero;
        s0_d.cls.sign = signA ^ signB;
        s0_d.cls.nan  = nan_any;
        s0_d.cls.inf  = (infA | infB) & ~nan_any;
        s0_d.cls.zero = (zeroA | zeroB) & ~(infA | infB | nan_any);
        if (prod_raw[2*FW+1]) begin
            s0_d.exp  = e_sum + ExpOne;
            s0_d.prod = prod_raw[2*FW:0];
        end else begin
            s0_d.exp  = e_sum;
            s0_d.prod = {prod_raw[2*FW-1:0], 1'b0};
        end
    end

    // Payload registers carry no reset; only the valid bits and the visible outputs do.
    for (genvar k = 0; k < LAT; k++) begin : g_stage
        if (k == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (ready[0] && in_valid) begin
                    pipe_q[0] <= s0_d;
                end
            end
        end else if (k < LAT - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (ready[k] && v_q[k-1]) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
            end
        end
    end

    assign tail = pipe_q[LAT-2];

    fround #(
        .FW (FW),
        .EW (EW)
    ) u_fround (
        .cls_i    (tail.cls),
        .nv_i     (tail.nv),
        .rm_i     (tail.rm),
        .exp_i    ($signed(tail.exp)),
        .prod_i   (tail.prod),
        .result_o (rnd_result),
        .flags_o  (rnd_flags)
    );

    assign out_load = ready[LAT-1] && v_q[LAT-2];

    always_comb begin
        result_d = result_q;
        tag_d    = tag_q;
        flags_d  = flags_q;
        if (out_load) begin
            result_d = rnd_result;
            tag_d    = tail.tag;
            flags_d  = rnd_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            result_q <= '0;
            tag_q    <= '0;
            flags_q  <= '0;
        end else begin
            v_q      <= v_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = v_q[LAT-1];
    assign result    = result_q;
    assign out_tag   = tag_q;
    assign fflags    = flags_q;

endmodule
